psum_collector: RTL

Parametrised back-end for the corelet datapath. It receives per-column partial sums from the MAC array, each column with its own valid. It accumulates them in place across passes into a row-addressed accumulator bank. On command it drains the bank through shift/ReLU/leaky-ReLU post-processing into a show-ahead output FIFO. It generalises the corelet's fixed valid-delay, SFP and OFIFO chain with variable depth, per-column write pointers, saturation and back-pressured draining.

---
 rtl/psum_collector_if.sv | 26 ++
 rtl/psum_collector.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector_if.sv
// Write/read bus of the partial-sum collector: per-column partial sums in,
// post-processed rows out through a show-ahead FIFO head.
interface psum_collector_if #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16
);
  logic [COL*PSUM_BW-1:0] in_psum;
  logic [COL-1:0]         in_valid;
  logic                   acc_en;
  logic                   ptr_clr;
  logic [COL*PSUM_BW-1:0] out_data;
  logic                   out_valid;
  logic                   out_rd;

  // MAC array / consumer side
  modport master (
    output in_psum, in_valid, acc_en, ptr_clr, out_rd,
    input  out_data, out_valid
  );

  // collector side
  modport slave (
    input  in_psum, in_valid, acc_en, ptr_clr, out_rd,
    output out_data, out_valid
  );
endinterface

// File: rtl/psum_collector.sv
// Partial-sum collector: per-column saturating accumulation into a row bank,
// drained through shift / ReLU / leaky-ReLU into a show-ahead output FIFO.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | accepting column writes, waiting for drain_start_i
// S_DRAIN | issuing one row read per cycle while the FIFO has room;
//         | column writes are dropped and flagged in err_o
module psum_collector #(
  parameter int COL        = 8,
  parameter int PSUM_BW    = 16,
  parameter int ACC_DEPTH  = 16,
  parameter int ADDR_BW    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  psum_collector_if.slave    bus,
  input  logic               drain_start_i,
  input  logic [ADDR_BW:0]   drain_len_i,
  input  logic [1:0]         shift_i,
  input  logic               relu_en_i,
  input  logic               lrelu_en_i,
  output logic               busy_o,
  output logic               err_o
);

  localparam int ROW_W   = COL * PSUM_BW;
  localparam int LEN_W   = ADDR_BW + 1;
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;

  localparam logic signed [PSUM_BW-1:0] SAT_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic signed [PSUM_BW-1:0] SAT_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_BW-1:0]        rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic                      issue;
  logic                      room;
  logic [CNT_W:0]            inflight;

  logic signed [PSUM_BW-1:0] acc_q [ACC_DEPTH][COL];
  logic [ADDR_BW-1:0]        wr_ptr_q [COL];
  logic signed [PSUM_BW-1:0] in_col [COL];
  logic signed [PSUM_BW-1:0] wr_val [COL];
  logic [COL-1:0]            wr_en;

  logic signed [PSUM_BW-1:0] shifted [COL];
  logic signed [PSUM_BW-1:0] pp_col [COL];
  logic [ROW_W-1:0]          pp_d, pp_q;
  logic                      pp_valid_q;

  logic [ROW_W-1:0]          fifo_mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]        fifo_wr_ptr_q, fifo_rd_ptr_q;
  logic [CNT_W-1:0]          fifo_cnt_q;
  logic                      fifo_push, fifo_pop;

  logic                      err_q;

  // Add in one extra bit; disagreeing top bits mean the sum left the range.
  function automatic logic signed [PSUM_BW-1:0] sat_add(
    input logic signed [PSUM_BW-1:0] a,
    input logic signed [PSUM_BW-1:0] b
  );
    logic [PSUM_BW:0] s;
    s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
    if (s[PSUM_BW] != s[PSUM_BW-1]) begin
      sat_add = s[PSUM_BW] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_add = s[PSUM_BW-1:0];
    end
  endfunction

  // Per-column write value: overwrite or saturating accumulate at the column's pointer.
  always_comb begin
    for (int c = 0; c < COL; c++) begin
      in_col[c] = bus.in_psum[c*PSUM_BW +: PSUM_BW];
      wr_val[c] = in_col[c];
      if (bus.acc_en) begin
        wr_val[c] = sat_add(acc_q[wr_ptr_q[c]][c], in_col[c]);
      end
      wr_en[c] = bus.in_valid[c] && (state_q != S_DRAIN);
    end
  end

  // Accumulator bank; each column writes its own row independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ACC_DEPTH; r++) begin
        for (int c = 0; c < COL; c++) begin
          acc_q[r][c] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < COL; c++) begin
        if (wr_en[c]) begin
          acc_q[wr_ptr_q[c]][c] <= wr_val[c];
        end
      end
    end
  end

  // Column write pointers; a clear in the same cycle as a write lets the write use the old pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COL; c++) begin
        wr_ptr_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < COL; c++) begin
        if (bus.ptr_clr) begin
          wr_ptr_q[c] <= '0;
        end else if (wr_en[c]) begin
          wr_ptr_q[c] <= wr_ptr_q[c] + ADDR_BW'(1);
        end
      end
    end
  end

  // Rows already buffered plus the one in the post-process stage must leave a free FIFO slot.
  always_comb begin
    inflight = {1'b0, fifo_cnt_q} + {{CNT_W{1'b0}}, pp_valid_q};
    room     = inflight < (CNT_W+1)'(FIFO_DEPTH);
  end

  // Drain FSM next-state and read issue.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    len_d     = len_q;
    issue     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (drain_start_i) begin
          state_d   = S_DRAIN;
          rd_addr_d = '0;
          len_d     = (drain_len_i == '0) ? LEN_W'(ACC_DEPTH) : drain_len_i;
        end
      end
      S_DRAIN: begin
        if (room) begin
          issue     = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_BW'(1);
          len_d     = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      len_q     <= len_d;
    end
  end

  // Post-processing of the row being read: shift, then ReLU or leaky ReLU on negatives.
  always_comb begin
    pp_d = '0;
    for (int c = 0; c < COL; c++) begin
      shifted[c] = acc_q[rd_addr_q][c] >>> shift_i;
      pp_col[c]  = shifted[c];
      if (shifted[c] < 0) begin
        if (relu_en_i) begin
          pp_col[c] = '0;
        end else if (lrelu_en_i) begin
          pp_col[c] = shifted[c] >>> 2;
        end
      end
      pp_d[c*PSUM_BW +: PSUM_BW] = pp_col[c];
    end
  end

  // Post-process output register; its valid is the single in-flight row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_q       <= '0;
      pp_valid_q <= 1'b0;
    end else begin
      pp_valid_q <= issue;
      if (issue) begin
        pp_q <= pp_d;
      end
    end
  end

  // Issue gating guarantees a push never finds the FIFO full.
  assign fifo_push = pp_valid_q;
  assign fifo_pop  = bus.out_rd && (fifo_cnt_q != '0);

  // Output FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      fifo_wr_ptr_q <= '0;
      fifo_rd_ptr_q <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      if (fifo_push) begin
        fifo_mem_q[fifo_wr_ptr_q] <= pp_q;
        fifo_wr_ptr_q             <= fifo_wr_ptr_q + FIFO_AW'(1);
      end
      if (fifo_pop) begin
        fifo_rd_ptr_q <= fifo_rd_ptr_q + FIFO_AW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Sticky error: writes dropped during a drain, or a pop from an empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (((|bus.in_valid) && (state_q == S_DRAIN)) ||
                 (bus.out_rd && (fifo_cnt_q == '0))) begin
      err_q <= 1'b1;
    end
  end

  assign bus.out_valid = (fifo_cnt_q != '0);
  assign bus.out_data  = bus.out_valid ? fifo_mem_q[fifo_rd_ptr_q] : '0;
  assign busy_o        = (state_q == S_DRAIN) || pp_valid_q;
  assign err_o         = err_q;

endmodule
